mem_bus_if: RTL and testbench

//  Data-side Wishbone B3 master for the MEM stage. It converts the MEM stage's single-cycle load/store request into a bus cycle.
//  - While the transfer is outstanding it raises stallreq_o to ctrl.
//  - It returns read data to the MEM stage, which forwards it to mem_wb.
//  - It holds the returned data stable while the pipeline stays stalled for other reasons.

---
 rtl/mem_bus_if_pkg.sv | 16 +
 rtl/mem_bus_if.sv | 127 ++++++++++++
 tb/tb_mem_bus_if.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if_pkg.sv
// Shared constants and state encoding for the MEM-stage Wishbone data master.
package mem_bus_if_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE       = 2'd0,
    BUS_BUSY       = 2'd1,
    BUS_WAIT_STALL = 2'd2
  } bus_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_bus_if.sv
// Data-side Wishbone B3 master: turns a single-cycle MEM-stage load/store into one bus cycle,
// stalling the pipeline until ack, timeout or flush.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  // A zero timeout still needs a one-bit counter so the logic stays well formed.
  localparam int unsigned     CNT_W   = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);

  bus_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rd_buf;

  logic w_req;
  logic w_stall_any;
  logic w_timeout;

  assign w_req       = cpu_ce_i && !flush;
  assign w_stall_any = |stall;
  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST) && !wb_ack_i;

  // Stall request and load data seen by the MEM stage in the current cycle.
  always_comb begin
    stallreq_o = NoStop;
    cpu_data_o = ZERO_DATA;
    case (r_state)
      BUS_IDLE: begin
        if (w_req) stallreq_o = Stop;
      end
      BUS_BUSY: begin
        if (flush) begin
          stallreq_o = NoStop;
        end else if (wb_ack_i) begin
          cpu_data_o = wb_we_o ? ZERO_DATA : wb_dat_i;
        end else if (!w_timeout) begin
          stallreq_o = Stop;
        end
      end
      BUS_WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
      end
      default: begin
        stallreq_o = NoStop;
      end
    endcase
  end

  // State, bus outputs, read buffer and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= BUS_IDLE;
      r_cnt     <= '0;
      r_rd_buf  <= ZERO_DATA;
      bus_err_o <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= ZERO_DATA;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (r_state)
        BUS_IDLE: begin
          if (w_req) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            r_cnt    <= '0;
            r_state  <= BUS_BUSY;
          end
        end
        BUS_BUSY: begin
          if (flush || wb_ack_i || w_timeout) begin
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            r_rd_buf  <= flush ? ZERO_DATA : cpu_data_o;
            bus_err_o <= !flush && w_timeout;
            r_state   <= (!flush && w_stall_any) ? BUS_WAIT_STALL : BUS_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BUS_WAIT_STALL: begin
          if (!w_stall_any || flush) r_state <= BUS_IDLE;
        end
        default: begin
          r_state <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed plus randomized bench for mem_bus_if with a transaction-level expectation model.
module tb_mem_bus_if;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;

  mem_bus_if #(
    .ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One MEM access. delay = BUSY cycles before the slave acks (>= TO never acks in time).
  // hold = cycles the pipeline stays stalled after the ending cycle; fl = flush in the ending cycle.
  task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                      input int hold, input bit fl);
    bit          timed_out = (delay >= TO);
    int          last      = timed_out ? TO - 1 : delay;
    logic [31:0] result    = (we || timed_out || fl) ? 32'h0 : rdata;
    bit          in_wait   = (hold > 0) && !fl;
    bit          err_exp   = timed_out && !fl;
    bit          ack_now;

    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    stall = 6'h0; flush = 1'b0; wb_ack_i = 1'b0; wb_dat_i = $urandom;
    #1;
    chk("req_stallreq", 32'(stallreq_o), 32'd1);
    chk("req_cyc", 32'(wb_cyc_o), 32'd0);

    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      cpu_addr_i = $urandom; cpu_data_i = $urandom; cpu_sel_i = 4'($urandom);
      ack_now  = (k == delay) && !timed_out;
      wb_ack_i = ack_now;
      wb_dat_i = ack_now ? rdata : $urandom;
      flush    = fl && (k == last);
      stall    = (k == last && hold > 0) ? 6'b011111 : 6'h0;
      #1;
      chk("busy_cyc", 32'(wb_cyc_o), 32'd1);
      chk("busy_stb", 32'(wb_stb_o), 32'd1);
      chk("busy_adr", wb_adr_o, addr);
      chk("busy_dat", wb_dat_o, wdata);
      chk("busy_we", 32'(wb_we_o), 32'(we));
      chk("busy_sel", 32'(wb_sel_o), 32'(sel));
      chk("busy_err", 32'(bus_err_o), 32'd0);
      chk("busy_stallreq", 32'(stallreq_o), (k < last) ? 32'd1 : 32'd0);
      chk("busy_data", cpu_data_o, (k == last) ? result : 32'h0);
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      cpu_ce_i = 1'b0; wb_ack_i = 1'b0; flush = 1'b0; wb_dat_i = $urandom;
      stall = (h < hold) ? 6'b011111 : 6'h0;
      #1;
      chk("post_cyc", 32'(wb_cyc_o), 32'd0);
      chk("post_stb", 32'(wb_stb_o), 32'd0);
      chk("post_stallreq", 32'(stallreq_o), 32'd0);
      chk("post_err", 32'(bus_err_o), (h == 0 && err_exp) ? 32'd1 : 32'd0);
      chk("post_data", cpu_data_o, in_wait ? result : 32'h0);
    end

    if (hold > 0) begin
      @(negedge clk);
      #1;
      chk("idle_data", cpu_data_o, 32'h0);
      chk("idle_err", 32'(bus_err_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 6'h0; flush = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_sel_i = 4'h0; cpu_data_i = 32'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_data", cpu_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Request masked by flush in IDLE starts nothing.
    @(negedge clk);
    cpu_ce_i = 1'b1; flush = 1'b1; cpu_addr_i = 32'h1000;
    #1;
    chk("flushreq_stallreq", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    cpu_ce_i = 1'b0; flush = 1'b0;
    #1;
    chk("flushreq_cyc", 32'(wb_cyc_o), 32'd0);

    xfer(1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0, 1'b0);
    xfer(1'b1, 32'h8000_0010, 4'b0011, 32'h0000_1234, 3, 32'hFFFF_FFFF, 0, 1'b0);
    xfer(1'b0, 32'h0000_0080, 4'hF, 32'h0, 0, 32'hA5A5A5A5, 4, 1'b0);
    xfer(1'b0, 32'h0000_00C0, 4'hF, 32'h0, 100, 32'h1111_2222, 0, 1'b0);
    xfer(1'b0, 32'h0000_0100, 4'hF, 32'h0, 2, 32'h3333_4444, 0, 1'b1);
    xfer(1'b0, 32'h0000_0104, 4'hF, 32'h0, 1, 32'h5555_6666, 2, 1'b1);
    xfer(1'b1, 32'h0000_0108, 4'h1, 32'hCAFE, 9, 32'h0, 2, 1'b0);

    // Reset in BUSY: bus cycle dropped, late ack ignored.
    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h2000; cpu_sel_i = 4'hF;
    @(negedge clk);
    cpu_ce_i = 1'b0;
    #1;
    chk("rstbusy_cyc_before", 32'(wb_cyc_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h7777_8888;
    #1;
    chk("rstbusy_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstbusy_stb", 32'(wb_stb_o), 32'd0);
    chk("rstbusy_data", cpu_data_o, 32'h0);
    chk("rstbusy_stallreq", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    wb_ack_i = 1'b0;
    #1;
    chk("rstbusy_after_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstbusy_after_data", cpu_data_o, 32'h0);
    chk("rstbusy_after_err", 32'(bus_err_o), 32'd0);

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom), $urandom, 4'($urandom), $urandom,
           int'($urandom_range(0, 11)), $urandom, int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
